// File: rtl/mem_banks_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_banks_responder_if
// Purpose  : Bundles the per-bank request/grant/response signals of the
//            banked memory responder.
//            master : drives requests, observes grant and responses
//            slave  : the responder itself
// Signals  : bank_req_i/bank_gnt_o       per-bank request valid / grant
//            bank_addr_i                 per-bank byte address
//            bank_wdata_i/bank_strb_i    per-bank write data / byte strobe
//            bank_atop_i                 per-bank atomic field (ignored)
//            bank_we_i                   per-bank write enable (1 = write)
//            bank_rvalid_o/bank_rdata_o  per-bank response valid / data
// Revision : 1.0 - initial release
// ============================================================================
interface mem_banks_responder_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AtopWidth = 6,
  parameter int unsigned NumBanks  = 2
);
  localparam int unsigned BW = DataWidth / NumBanks;

  logic [NumBanks-1:0]                 bank_req_i;
  logic [NumBanks-1:0]                 bank_gnt_o;
  logic [NumBanks-1:0][AddrWidth-1:0]  bank_addr_i;
  logic [NumBanks-1:0][BW-1:0]         bank_wdata_i;
  logic [NumBanks-1:0][BW/8-1:0]       bank_strb_i;
  logic [NumBanks-1:0][AtopWidth-1:0]  bank_atop_i;
  logic [NumBanks-1:0]                 bank_we_i;
  logic [NumBanks-1:0]                 bank_rvalid_o;
  logic [NumBanks-1:0][BW-1:0]         bank_rdata_o;

  modport master (
    output bank_req_i, bank_addr_i, bank_wdata_i, bank_strb_i, bank_atop_i, bank_we_i,
    input  bank_gnt_o, bank_rvalid_o, bank_rdata_o
  );

  modport slave (
    input  bank_req_i, bank_addr_i, bank_wdata_i, bank_strb_i, bank_atop_i, bank_we_i,
    output bank_gnt_o, bank_rvalid_o, bank_rdata_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_banks_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_banks_responder
// Purpose  : NumBanks independent single-port memory banks. Each bank grants
//            a request when not busy, services it at the accepting edge and
//            returns a response exactly Latency cycles later through a
//            valid-tagged shift pipeline. Writes apply byte strobes and make
//            the bank busy for WrBusy cycles.
// Ports    : clk_i  - clock, rising edge
//            rst_i  - asynchronous active-high reset (clears arrays too)
//            bus    - mem_banks_responder_if.slave, per-bank request/response
// Revision : 1.0 - initial release
// ============================================================================
module mem_banks_responder #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AtopWidth = 6,
  parameter int unsigned NumBanks  = 2,
  parameter int unsigned Depth     = 16,
  parameter int unsigned Latency   = 1,
  parameter int unsigned WrBusy    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mem_banks_responder_if.slave  bus
);
  localparam int BW      = DataWidth / NumBanks;
  localparam int SW      = BW / 8;
  // The word index is taken from the full-width byte address, not the
  // per-bank width, so every bank sees the same address-to-index mapping.
  localparam int OffBits = $clog2(DataWidth / 8);
  localparam int IdxBits = $clog2(Depth);
  localparam int BusyW   = 3;

  // The atomic field and the address bits above the index carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{bus.bank_atop_i, bus.bank_addr_i};

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    logic [BW-1:0]              mem_q [Depth];
    logic [BW-1:0]              mem_d [Depth];
    logic [BusyW-1:0]           busy_q, busy_d;
    logic [Latency-1:0]         vld_q, vld_d;
    logic [Latency-1:0][BW-1:0] dat_q, dat_d;
    logic [IdxBits-1:0]         idx;
    logic                       gnt;
    logic                       acc;
    logic [BW-1:0]              old_word;
    logic [BW-1:0]              new_word;
    logic [BW-1:0]              resp_word;

    assign idx = bus.bank_addr_i[b][OffBits +: IdxBits];
    assign gnt = bus.bank_req_i[b] & (busy_q == '0);
    assign acc = gnt;

    assign bus.bank_gnt_o[b]    = gnt;
    assign bus.bank_rvalid_o[b] = vld_q[Latency-1];
    assign bus.bank_rdata_o[b]  = vld_q[Latency-1] ? dat_q[Latency-1] : '0;

    // Strobe merge; a write responds with the merged (post-write) word.
    always_comb begin
      old_word = mem_q[idx];
      new_word = old_word;
      for (int i = 0; i < SW; i++) begin
        if (bus.bank_strb_i[b][i]) begin
          new_word[i*8 +: 8] = bus.bank_wdata_i[b][i*8 +: 8];
        end
      end
      resp_word = bus.bank_we_i[b] ? new_word : old_word;
    end

    always_comb begin
      for (int i = 0; i < Depth; i++) begin
        mem_d[i] = mem_q[i];
      end
      if (acc && bus.bank_we_i[b]) begin
        mem_d[idx] = new_word;
      end
    end

    // Busy can only be loaded when it is already zero (grant requires it),
    // so load and decrement never collide.
    always_comb begin
      busy_d = busy_q;
      if (acc && bus.bank_we_i[b]) begin
        busy_d = BusyW'(WrBusy);
      end else if (busy_q != '0) begin
        busy_d = busy_q - BusyW'(1);
      end
    end

    // Stage 0 captures the response at acceptance; later stages just shift,
    // giving one response per cycle with no bubbles and in order.
    always_comb begin
      vld_d    = '0;
      dat_d    = '0;
      vld_d[0] = acc;
      dat_d[0] = resp_word;
      for (int i = 1; i < Latency; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        busy_q <= '0;
        vld_q  <= '0;
        dat_q  <= '0;
        for (int i = 0; i < Depth; i++) begin
          mem_q[i] <= '0;
        end
      end else begin
        busy_q <= busy_d;
        vld_q  <= vld_d;
        dat_q  <= dat_d;
        for (int i = 0; i < Depth; i++) begin
          mem_q[i] <= mem_d[i];
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_banks_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_banks_responder
// Purpose  : Self-checking bench for mem_banks_responder (2 banks, 64-bit,
//            Latency 3, WrBusy 2). Expected responses are pushed into
//            per-bank queues when a request is accepted; a monitor pops and
//            compares them against the DUT responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_banks_responder;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 64;
  localparam int unsigned ATW   = 6;
  localparam int unsigned NB    = 2;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT   = 3;
  localparam int unsigned WRB   = 2;
  localparam int unsigned BW    = DW / NB;
  localparam int unsigned SW    = BW / 8;

  typedef struct packed {
    logic [BW-1:0] data;
    int unsigned   due;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_banks_responder_if #(.AddrWidth(AW), .DataWidth(DW), .AtopWidth(ATW), .NumBanks(NB)) bus ();

  mem_banks_responder #(
    .AddrWidth(AW), .DataWidth(DW), .AtopWidth(ATW), .NumBanks(NB),
    .Depth(DEPTH), .Latency(LAT), .WrBusy(WRB)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Staged request per bank, applied by step()
  logic [NB-1:0] st_req, st_we, last_acc;
  logic [AW-1:0] st_addr  [NB];
  logic [BW-1:0] st_wdata [NB];
  logic [SW-1:0] st_strb  [NB];

  // Reference model
  logic [BW-1:0] mdl_mem [NB][DEPTH];
  int unsigned   busy_until [NB];
  resp_t         exp_q [NB][$];
  resp_t         mon_r;
  logic          mon_v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int unsigned idx_of(input logic [AW-1:0] a);
    return (a / (DW / 8)) % DEPTH;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      busy_until[b] = 0;
      exp_q[b].delete();
      for (int i = 0; i < DEPTH; i++) mdl_mem[b][i] = '0;
    end
  endtask

  task automatic drive_bus();
    bus.bank_req_i = st_req;
    bus.bank_we_i  = st_we;
    for (int b = 0; b < NB; b++) begin
      bus.bank_addr_i[b]  = st_addr[b];
      bus.bank_wdata_i[b] = st_wdata[b];
      bus.bank_strb_i[b]  = st_strb[b];
    end
  endtask

  // One clock cycle: apply staged requests, check grants against the model
  // at the falling edge, record accepted requests, return at posedge+1.
  task automatic step();
    logic [BW-1:0] old_w, new_w;
    int unsigned   ix;
    logic          eg;
    drive_bus();
    @(negedge clk);
    last_acc = '0;
    for (int b = 0; b < NB; b++) begin
      eg = st_req[b] && (cyc >= busy_until[b]);
      check("gnt", {63'd0, bus.bank_gnt_o[b]}, {63'd0, eg});
      if (eg) begin
        last_acc[b] = 1'b1;
        ix    = idx_of(st_addr[b]);
        old_w = mdl_mem[b][ix];
        if (st_we[b]) begin
          new_w = old_w;
          for (int k = 0; k < SW; k++)
            if (st_strb[b][k]) new_w[k*8 +: 8] = st_wdata[b][k*8 +: 8];
          mdl_mem[b][ix] = new_w;
          busy_until[b]  = cyc + WRB + 1;
          exp_q[b].push_back('{data: new_w, due: cyc + LAT});
        end else begin
          exp_q[b].push_back('{data: old_w, due: cyc + LAT});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    st_req = '0;
    st_we  = '0;
  endtask

  task automatic set_req(input int b, input logic we, input logic [AW-1:0] a,
                         input logic [BW-1:0] d, input logic [SW-1:0] s);
    st_req[b]   = 1'b1;
    st_we[b]    = we;
    st_addr[b]  = a;
    st_wdata[b] = d;
    st_strb[b]  = s;
  endtask

  // Hold a single-bank request until granted; n = cycles taken.
  task automatic hold_req(input int b, input logic we, input logic [AW-1:0] a,
                          input logic [BW-1:0] d, input logic [SW-1:0] s, output int n);
    clear_req();
    set_req(b, we, a, d, s);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      n++;
      if (last_acc[b]) break;
    end
    if (!last_acc[b]) check("gnt_timeout", {63'd0, last_acc[b]}, 64'd1);
    clear_req();
  endtask

  // Response monitor
  always @(negedge clk) begin
    for (int b = 0; b < NB; b++) begin
      mon_v = (exp_q[b].size() != 0) && (exp_q[b][0].due <= cyc);
      check("rvalid", {63'd0, bus.bank_rvalid_o[b]}, {63'd0, mon_v});
      if (mon_v) begin
        mon_r = exp_q[b].pop_front();
        check("rdata", {32'd0, bus.bank_rdata_o[b]}, {32'd0, mon_r.data});
      end else begin
        check("rdata_idle", {32'd0, bus.bank_rdata_o[b]}, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    model_reset();
    clear_req();
    for (int b = 0; b < NB; b++) begin
      st_addr[b] = '0; st_wdata[b] = '0; st_strb[b] = '0;
    end
    bus.bank_atop_i = '0;
    drive_bus();
    #1;
    check("reset_rvalid", {62'd0, bus.bank_rvalid_o}, 64'd0);
    check("reset_rdata0", {32'd0, bus.bank_rdata_o[0]}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Array comes out of reset as zero
    hold_req(0, 1'b0, 32'h08, '0, '0, n);
    // Full write then read of the same word; the read waits out WrBusy
    hold_req(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, n);
    hold_req(0, 1'b0, 32'h08, '0, '0, n);
    check("busy_wait", n, WRB + 1);
    // Partial strobe write, then readback, then wrapped alias 0x88
    hold_req(0, 1'b1, 32'h08, 32'h11223344, 4'h3, n);
    hold_req(0, 1'b0, 32'h08, '0, '0, n);
    hold_req(0, 1'b0, 32'h88, '0, '0, n);
    // Zero-strobe write still responds, leaves data alone
    hold_req(0, 1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, n);
    hold_req(0, 1'b0, 32'h08, '0, '0, n);

    // Back-to-back reads on bank1
    for (int i = 0; i < 4; i++)
      hold_req(1, 1'b1, AW'(i * 8), 32'hA5A50000 + i, 4'hF, n);
    repeat (WRB + 1) step();
    for (int i = 0; i < 4; i++) begin
      clear_req();
      set_req(1, 1'b0, AW'(i * 8), '0, '0);
      step();
      check("b2b_accept", {63'd0, last_acc[1]}, 64'd1);
    end
    clear_req();
    repeat (LAT + 2) step();

    // Simultaneous requests on both banks
    set_req(0, 1'b1, 32'h30, 32'h01020304, 4'hF);
    set_req(1, 1'b0, 32'h10, '0, '0);
    step();
    check("both_accept", {62'd0, last_acc}, 64'd3);
    clear_req();
    repeat (WRB + 1) step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < NB; b++) begin
        st_req[b]   = ($urandom_range(0, 3) != 0);
        st_we[b]    = 1'($urandom_range(0, 1));
        st_addr[b]  = $urandom;
        st_wdata[b] = $urandom;
        st_strb[b]  = 4'($urandom_range(0, 15));
        bus.bank_atop_i[b] = 6'($urandom_range(0, 63));
      end
      step();
    end
    clear_req();
    repeat (WRB + LAT + 2) step();

    // Reset with reads in flight on bank1
    for (int i = 0; i < 3; i++) begin
      clear_req();
      set_req(1, 1'b0, AW'(i * 8), '0, '0);
      step();
    end
    clear_req();
    drive_bus();
    check("pre_reset_rvalid", {63'd0, bus.bank_rvalid_o[1]}, 64'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rvalid", {62'd0, bus.bank_rvalid_o}, 64'd0);
    check("async_rdata", {32'd0, bus.bank_rdata_o[1]}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (LAT + 2) step();
    hold_req(1, 1'b0, 32'h08, '0, '0, n);
    repeat (LAT + 2) step();

    for (int b = 0; b < NB; b++)
      check("drain", 64'(exp_q[b].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_banks_responder.md
MEM_BANKS_RESPONDER -- requirements
Module: mem_banks_responder

Interface
REQ-001 Parameter AddrWidth, default 32, SHALL give the byte-address width of each bank request.
REQ-002 Parameter DataWidth, default 64, SHALL give the total data width across all banks; it SHALL be a power of two and at least 8*NumBanks.
REQ-003 Parameter AtopWidth, default 6, SHALL give the atomic-operation field width; the field is accepted and ignored.
REQ-004 Parameter NumBanks, default 2, SHALL give the number of independent banks; it SHALL be a power of two and SHALL evenly divide DataWidth.
REQ-005 Parameter Depth, default 16, SHALL give the words per bank; it SHALL be a power of two and at least 2.
REQ-006 Parameter Latency, default 1, SHALL give the grant-to-rvalid delay in cycles; it SHALL be between 1 and 8.
REQ-007 Parameter WrBusy, default 0, SHALL give the number of cycles a bank withholds grant after an accepted write; it SHALL be between 0 and 7.
REQ-008 Derived width BW = DataWidth/NumBanks SHALL apply per bank.
REQ-009 Port clk_i, in, 1: the single clock, rising edge.
REQ-010 Port rst_i, in, 1: asynchronous active-high reset.
REQ-011 Port bank_req_i, in, NumBanks: per-bank request valid.
REQ-012 Port bank_gnt_o, out, NumBanks: per-bank grant.
REQ-013 Port bank_addr_i, in, NumBanks x AddrWidth: per-bank byte address.
REQ-014 Port bank_wdata_i, in, NumBanks x BW: per-bank write data.
REQ-015 Port bank_strb_i, in, NumBanks x BW/8: per-bank byte strobe.
REQ-016 Port bank_atop_i, in, NumBanks x AtopWidth: per-bank atomic field, ignored.
REQ-017 Port bank_we_i, in, NumBanks: per-bank write enable, high = write.
REQ-018 Port bank_rvalid_o, out, NumBanks: per-bank response valid.
REQ-019 Port bank_rdata_o, out, NumBanks x BW: per-bank read data.

Function
REQ-020 Each bank b SHALL operate independently and hold a private array of Depth x BW bits.
REQ-021 Word index SHALL be bank_addr_i[b] / (DataWidth/8), taken modulo Depth; higher address bits are ignored, so the index wraps.
REQ-022 bank_gnt_o[b] SHALL be combinational and equal bank_req_i[b] AND (busy counter of bank b == 0).
REQ-023 A request is accepted on a cycle in which req and gnt are both high.
REQ-024 An accepted write SHALL update only the bytes whose strobe bit is set, at the clock edge of acceptance; a write with an all-zero strobe SHALL leave the array unchanged but still produce a response.
REQ-025 An accepted write SHALL load the bank busy counter with WrBusy; the counter SHALL decrement by 1 per cycle to 0 and SHALL not underflow.
REQ-026 An accepted read or write SHALL raise bank_rvalid_o[b] for exactly one cycle, exactly Latency cycles after acceptance.
REQ-027 A valid-tagged Latency-stage shift pipeline per bank SHALL allow back-to-back accepts (one per cycle) with no bubble and in-order responses.
REQ-028 For reads, bank_rdata_o[b] SHALL carry the array word as sampled at acceptance, delayed Latency cycles; for writes it SHALL carry the post-write word.
REQ-029 When bank_rvalid_o[b] is low, bank_rdata_o[b] SHALL be 0.
REQ-030 A read accepted on the cycle after a write to the same index SHALL return the new data (read-after-write, no hazard).
REQ-031 Requests arriving simultaneously on different banks SHALL all be accepted in the same cycle, with no cross-bank interaction.
REQ-032 The block SHALL not apply back-pressure on responses; no response SHALL be dropped.

Reset
REQ-033 While rst_i is high, bank_rvalid_o SHALL be 0, bank_rdata_o SHALL be 0, all pipeline valid tags SHALL be 0, and all busy counters SHALL be 0, with immediate (asynchronous) effect.
REQ-034 Array contents SHALL reset to 0.
REQ-035 Reset asserted mid-operation SHALL discard in-flight responses; no rvalid SHALL appear after reset deasserts unless a new request is accepted.

Verification
REQ-036 NumBanks=2, DataWidth=64, Latency=1, Depth=16: write bank0 addr 0x08, data 0xDEADBEEF, strobe 0xF; read addr 0x08 the next cycle -> rvalid one cycle after each accept; read returns 0xDEADBEEF.
REQ-037 Strobe 0x3 write of 0x11223344 over stored 0xDEADBEEF -> read returns 0xDEAD3344.
REQ-038 Latency=3: four back-to-back reads on bank1 -> rvalid high for 4 consecutive cycles beginning 3 cycles after the first accept; data in order.
REQ-039 WrBusy=2: write accepted at cycle t with req held high -> gnt low at t+1 and t+2, high at t+3.
REQ-040 Address 0x88 with Depth=16 and DataWidth=64 -> index 1 (wrap); reads data written at 0x08.
REQ-041 rst_i pulsed with two reads in flight at Latency=3 -> no rvalid afterwards; a subsequent read returns 0.
